superscalar_commit_stage: RTL and testbench
===========================================

# superscalar_commit_stage

Parametrised in-order commit stage that retires up to `W` ROB head entries per cycle. It sits between the ROB and the regfile, map table and data memory. Stores are serialised through a request/acknowledge handshake with data memory, so memory is written only at retirement. A halt instruction stops all further retirement until reset, and a free-running counter reports the number of retired instructions.

## Interface
Parameters:
- `W`, default 2: commit width, valid range 1..4
- `ROB_DEPTH`, default 16: ROB entries, power of two
- `TAG_W`, default `$clog2(ROB_DEPTH)`: ROB tag width
- `CNT_W`, default `$clog2(W+1)`: width of `commit_count`

Ports:
- `clock`  in  1  system clock; all flops on its rising edge
- `reset`  in  1  asynchronous, active-low reset
- `head_entries`  in  W×ROB_ENTRY  ROB entries head+0 .. head+W-1; fields used: valid, NPC, inst, value, mem_size, wr_mem, dest_addr, dest_reg
- `head_ready`  in  W  per-slot result-ready flag
- `head_halt`  in  W  per-slot "instruction is halt" flag
- `head_tag`  in  TAG_W  ROB tag of slot 0
- `mem_ack`  in  1  data memory accepted the store request
- `commit_count`  out  CNT_W  entries retired this cycle (combinational); ROB advances head by this value at the edge
- `cmt_packet_out`  out  W×COMMIT_PACKET  registered commit packets, one per slot
- `mem_req_valid`  out  1  store request, registered
- `mem_req_addr`  out  32  store address
- `mem_req_data`  out  32  store data
- `mem_req_size`  out  MEM_SIZE  store size
- `halted`  out  1  sticky halt flag
- `retired_total`  out  32  retired-instruction counter

## Operation
- Slot i is eligible when `valid`, `head_ready[i]` and all slots below i are eligible (in-order prefix).
- FSM states: RUN, STORE_WAIT, HALTED. Reset state is RUN.
- RUN:
  - Retire the eligible prefix, with two truncation rules.
    - A store (`wr_mem=1`) in slot k>0 truncates the prefix before slot k.
    - A halt in slot k truncates the prefix after slot k; the halt itself retires.
  - If slot 0 is an eligible store:
    - `commit_count=0`.
    - Next edge: load the `mem_req_*` registers from slot 0 (`dest_addr`, `value`, `mem_size`), set `mem_req_valid=1`, go to STORE_WAIT.
  - If a halt retired: go to HALTED.
- STORE_WAIT:
  - Hold `mem_req_*` stable.
  - While `mem_ack=0`: `commit_count=0`.
  - Cycle with `mem_ack=1`:
    - `commit_count=1` (the store retires).
    - Next edge: `mem_req_valid=0`, state RUN.
  - `mem_ack` is ignored while `mem_req_valid=0`.
- HALTED: `commit_count=0` forever; `halted=1`. Only reset exits.
- Packet generation (registered, one cycle after retirement), for slot i < `commit_count`:
  - `valid=1`
  - `NPC`, `inst`, `data_out=value`, `mem_size` copied from the entry
  - `mem_address=dest_addr`
  - `wr_mem=0`: the memory write was already performed by the handshake
  - `reg_wr_idx_out=dest_reg`
  - `reg_wr_en_out = (dest_reg != ZERO_REG)`
  - `rob_tag = (head_tag + i) mod ROB_DEPTH`, TAG_W-bit wrap
- Slots ≥ `commit_count` drive valid=0 and reg_wr_en_out=0; their other fields are don't-care.
- `retired_total += commit_count` each edge; wraps modulo 2^32.

## Timing
- Reset (async assert, sync-safe deassert):
  - State RUN, `halted=0`, `mem_req_valid=0`.
  - `mem_req_*` and `retired_total` = 0.
  - All `cmt_packet_out` fields = 0.
- `commit_count` is combinational from state and inputs; there is no input-to-register bypass.
- Packet latency: retire in cycle N → `cmt_packet_out` valid in cycle N+1.
- Store latency: minimum 2 cycles.
  - Cycle N: detect the store.
  - Cycle N+1: `mem_req_valid=1`; if `mem_ack=1` in N+1, the store retires in N+1.
- Halt retirement: `halted` rises at edge N+1.
- Reset asserted in STORE_WAIT: `mem_req_valid` drops immediately (async); no retirement occurs.

## Test plan
- W=2, `head_tag=15`, two ready ALU ops writing x5, x6 → `commit_count=2`; next cycle both packets valid with reg_wr_en=1 and tags 15 and 0; `retired_total=2`.
- Slot 0 not ready, slot 1 ready → `commit_count=0`. Slot 0 ready, slot 1 not ready → `commit_count=1`.
- ALU in slot 0, store in slot 1 (addr 0x100, data 0xDEAD), `mem_ack` held low 3 cycles after the request → ALU retires first (count 1); store then appears in slot 0 → count 0; next cycle `mem_req_valid=1`, addr 0x100 held 3 cycles; on ack, count 1; next cycle packet with wr_mem=0 and mem_req_valid=0.
- Halt in slot 0, ready ALU in slot 1 → `commit_count=1`; `halted=1` next cycle; later ready entries give count 0 until reset.
- Ready op with dest x0 → packet valid=1, reg_wr_en_out=0.
- Assert reset during STORE_WAIT → `mem_req_valid=0` before the next edge; `retired_total=0`; after release, a fresh ALU commit works normally.

Source files
------------

// File: rtl/superscalar_commit_stage_if.sv
// rtl/superscalar_commit_stage_if.sv - ROB head, commit packet and store handshake bundle
// Entry and packet fields are split into per-field packed arrays indexed by slot.
interface superscalar_commit_stage_if #(
  parameter int W         = 2,
  parameter int ROB_DEPTH = 16,
  parameter int TAG_W     = $clog2(ROB_DEPTH),
  parameter int CNT_W     = $clog2(W + 1)
);
  logic [W-1:0]            head_valid;
  logic [W-1:0][31:0]      head_npc;
  logic [W-1:0][31:0]      head_inst;
  logic [W-1:0][31:0]      head_value;
  logic [W-1:0][1:0]       head_mem_size;
  logic [W-1:0]            head_wr_mem;
  logic [W-1:0][31:0]      head_dest_addr;
  logic [W-1:0][4:0]       head_dest_reg;
  logic [W-1:0]            head_ready;
  logic [W-1:0]            head_halt;
  logic [TAG_W-1:0]        head_tag;
  logic                    mem_ack;

  logic [CNT_W-1:0]        commit_count;
  logic [W-1:0]            pkt_valid;
  logic [W-1:0][31:0]      pkt_npc;
  logic [W-1:0][31:0]      pkt_inst;
  logic [W-1:0][31:0]      pkt_data_out;
  logic [W-1:0][31:0]      pkt_mem_address;
  logic [W-1:0][1:0]       pkt_mem_size;
  logic [W-1:0]            pkt_wr_mem;
  logic [W-1:0][4:0]       pkt_reg_wr_idx;
  logic [W-1:0]            pkt_reg_wr_en;
  logic [W-1:0][TAG_W-1:0] pkt_rob_tag;
  logic                    mem_req_valid;
  logic [31:0]             mem_req_addr;
  logic [31:0]             mem_req_data;
  logic [1:0]              mem_req_size;
  logic                    halted;
  logic [31:0]             retired_total;

  modport slave (
    input  head_valid, head_npc, head_inst, head_value, head_mem_size, head_wr_mem,
           head_dest_addr, head_dest_reg, head_ready, head_halt, head_tag, mem_ack,
    output commit_count, pkt_valid, pkt_npc, pkt_inst, pkt_data_out, pkt_mem_address,
           pkt_mem_size, pkt_wr_mem, pkt_reg_wr_idx, pkt_reg_wr_en, pkt_rob_tag,
           mem_req_valid, mem_req_addr, mem_req_data, mem_req_size, halted, retired_total
  );

  modport master (
    output head_valid, head_npc, head_inst, head_value, head_mem_size, head_wr_mem,
           head_dest_addr, head_dest_reg, head_ready, head_halt, head_tag, mem_ack,
    input  commit_count, pkt_valid, pkt_npc, pkt_inst, pkt_data_out, pkt_mem_address,
           pkt_mem_size, pkt_wr_mem, pkt_reg_wr_idx, pkt_reg_wr_en, pkt_rob_tag,
           mem_req_valid, mem_req_addr, mem_req_data, mem_req_size, halted, retired_total
  );
endinterface

// File: rtl/superscalar_commit_stage.sv
// rtl/superscalar_commit_stage.sv - In-order W-wide commit stage with serialised stores
// Retires the ready prefix of the ROB head; stores go through a req/ack handshake first.
module superscalar_commit_stage #(
  parameter int W         = 2,
  parameter int ROB_DEPTH = 16,
  parameter int TAG_W     = $clog2(ROB_DEPTH),
  parameter int CNT_W     = $clog2(W + 1)
) (
  input logic                       clock,
  input logic                       reset,
  superscalar_commit_stage_if.slave bus
);
  localparam logic [4:0] ZERO_REG = 5'd0;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_STORE_WAIT = 2'd1,
    ST_HALTED     = 2'd2
  } state_t;

  state_t                  r_state;
  logic                    r_mem_req_valid;
  logic [31:0]             r_mem_req_addr;
  logic [31:0]             r_mem_req_data;
  logic [1:0]              r_mem_req_size;
  logic [31:0]             r_retired_total;
  logic [W-1:0]            r_pkt_valid;
  logic [W-1:0][31:0]      r_pkt_npc;
  logic [W-1:0][31:0]      r_pkt_inst;
  logic [W-1:0][31:0]      r_pkt_data_out;
  logic [W-1:0][31:0]      r_pkt_mem_address;
  logic [W-1:0][1:0]       r_pkt_mem_size;
  logic [W-1:0][4:0]       r_pkt_reg_wr_idx;
  logic [W-1:0]            r_pkt_reg_wr_en;
  logic [W-1:0][TAG_W-1:0] r_pkt_rob_tag;

  logic [CNT_W-1:0]        w_count;
  logic [W-1:0]            w_retire;
  logic                    w_store_start;
  logic                    w_halt_retire;
  logic                    w_stop;
  logic                    w_ack;

  assign w_ack = bus.mem_ack & r_mem_req_valid;

  // Walk the slots in order; the first ineligible slot, a younger store, or a retired halt ends the group.
  always_comb begin
    w_count       = '0;
    w_retire      = '0;
    w_store_start = 1'b0;
    w_halt_retire = 1'b0;
    w_stop        = 1'b0;
    case (r_state)
      ST_RUN: begin
        for (int i = 0; i < W; i++) begin
          if (!w_stop) begin
            if (!(bus.head_valid[i] && bus.head_ready[i])) begin
              w_stop = 1'b1;
            end else if (bus.head_wr_mem[i]) begin
              w_stop = 1'b1;
              if (i == 0) w_store_start = 1'b1;
            end else begin
              w_retire[i] = 1'b1;
              w_count     = CNT_W'(i + 1);
              if (bus.head_halt[i]) begin
                w_halt_retire = 1'b1;
                w_stop        = 1'b1;
              end
            end
          end
        end
      end
      ST_STORE_WAIT: begin
        w_retire[0] = w_ack;
        w_count     = CNT_W'(w_ack);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state           <= ST_RUN;
      r_mem_req_valid   <= 1'b0;
      r_mem_req_addr    <= '0;
      r_mem_req_data    <= '0;
      r_mem_req_size    <= '0;
      r_retired_total   <= '0;
      r_pkt_valid       <= '0;
      r_pkt_npc         <= '0;
      r_pkt_inst        <= '0;
      r_pkt_data_out    <= '0;
      r_pkt_mem_address <= '0;
      r_pkt_mem_size    <= '0;
      r_pkt_reg_wr_idx  <= '0;
      r_pkt_reg_wr_en   <= '0;
      r_pkt_rob_tag     <= '0;
    end else begin
      r_retired_total <= r_retired_total + 32'(w_count);
      case (r_state)
        ST_RUN: begin
          if (w_store_start) begin
            r_state         <= ST_STORE_WAIT;
            r_mem_req_valid <= 1'b1;
            r_mem_req_addr  <= bus.head_dest_addr[0];
            r_mem_req_data  <= bus.head_value[0];
            r_mem_req_size  <= bus.head_mem_size[0];
          end else if (w_halt_retire) begin
            r_state <= ST_HALTED;
          end
        end
        ST_STORE_WAIT: begin
          if (w_ack) begin
            r_state         <= ST_RUN;
            r_mem_req_valid <= 1'b0;
          end
        end
        ST_HALTED: ;
        default: r_state <= ST_RUN;
      endcase
      // Payload loads every edge; only valid and write-enable carry meaning for unretired slots.
      for (int i = 0; i < W; i++) begin
        r_pkt_valid[i]       <= w_retire[i];
        r_pkt_npc[i]         <= bus.head_npc[i];
        r_pkt_inst[i]        <= bus.head_inst[i];
        r_pkt_data_out[i]    <= bus.head_value[i];
        r_pkt_mem_address[i] <= bus.head_dest_addr[i];
        r_pkt_mem_size[i]    <= bus.head_mem_size[i];
        r_pkt_reg_wr_idx[i]  <= bus.head_dest_reg[i];
        r_pkt_reg_wr_en[i]   <= w_retire[i] && (bus.head_dest_reg[i] != ZERO_REG);
        r_pkt_rob_tag[i]     <= bus.head_tag + TAG_W'(i);
      end
    end
  end

  assign bus.commit_count    = w_count;
  assign bus.pkt_valid       = r_pkt_valid;
  assign bus.pkt_npc         = r_pkt_npc;
  assign bus.pkt_inst        = r_pkt_inst;
  assign bus.pkt_data_out    = r_pkt_data_out;
  assign bus.pkt_mem_address = r_pkt_mem_address;
  assign bus.pkt_mem_size    = r_pkt_mem_size;
  assign bus.pkt_wr_mem      = '0;
  assign bus.pkt_reg_wr_idx  = r_pkt_reg_wr_idx;
  assign bus.pkt_reg_wr_en   = r_pkt_reg_wr_en;
  assign bus.pkt_rob_tag     = r_pkt_rob_tag;
  assign bus.mem_req_valid   = r_mem_req_valid;
  assign bus.mem_req_addr    = r_mem_req_addr;
  assign bus.mem_req_data    = r_mem_req_data;
  assign bus.mem_req_size    = r_mem_req_size;
  assign bus.halted          = (r_state == ST_HALTED);
  assign bus.retired_total   = r_retired_total;
endmodule

// File: tb/tb_superscalar_commit_stage.sv
// tb/tb_superscalar_commit_stage.sv - Directed and randomized checks of the commit stage
module tb_superscalar_commit_stage;
  localparam int W         = 2;
  localparam int ROB_DEPTH = 16;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  int          m_total = 0;
  bit          m_sw = 1'b0;
  bit          m_halted = 1'b0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_data = '0;
  logic [1:0]  m_size = '0;

  superscalar_commit_stage_if #(.W(W), .ROB_DEPTH(ROB_DEPTH)) bus ();
  superscalar_commit_stage #(.W(W), .ROB_DEPTH(ROB_DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic set_slot(input int i, input bit v, input bit rdy, input bit hlt, input bit st,
                          input logic [4:0] rd, input logic [31:0] addr, input logic [31:0] val);
    bus.head_valid[i]     = v;
    bus.head_ready[i]     = rdy;
    bus.head_halt[i]      = hlt;
    bus.head_wr_mem[i]    = st;
    bus.head_dest_reg[i]  = rd;
    bus.head_dest_addr[i] = addr;
    bus.head_value[i]     = val;
    bus.head_npc[i]       = $urandom & 32'hffff_fffc;
    bus.head_inst[i]      = $urandom;
    bus.head_mem_size[i]  = 2'($urandom_range(0, 2));
  endtask

  task automatic clear_slots();
    for (int i = 0; i < W; i++) set_slot(i, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
  endtask

  // Reference: length of the ready run, cut at a younger store or just after a halt.
  function automatic int model_count(output bit store_seen, output bit halt_seen);
    int n, s, h, cnt;
    store_seen = 1'b0;
    halt_seen  = 1'b0;
    if (m_halted) return 0;
    if (m_sw) return bus.mem_ack ? 1 : 0;
    n = 0;
    while (n < W && bus.head_valid[n] === 1'b1 && bus.head_ready[n] === 1'b1) n++;
    s = -1;
    h = -1;
    for (int j = 0; j < n; j++) begin
      if (s < 0 && bus.head_wr_mem[j]) s = j;
      if (h < 0 && bus.head_halt[j]) h = j;
    end
    if (s == 0) begin
      store_seen = 1'b1;
      return 0;
    end
    cnt = n;
    if (s > 0 && s < cnt) cnt = s;
    if (h >= 0 && h + 1 < cnt) cnt = h + 1;
    halt_seen = (h >= 0 && h < cnt);
    return cnt;
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    clear_slots();
    bus.head_tag = '0;
    bus.mem_ack  = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    n_tests++; if (bus.mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req_valid got %0b want 0", bus.mem_req_valid); end
    n_tests++; if (bus.halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted got %0b want 0", bus.halted); end
    n_tests++; if (bus.retired_total !== 32'd0) begin n_fail++; $display("FAIL reset_retired got %0d want 0", bus.retired_total); end
    n_tests++; if (bus.pkt_valid !== 2'b00) begin n_fail++; $display("FAIL reset_pkt_valid got %b want 00", bus.pkt_valid); end
    n_tests++; if (bus.pkt_npc[0] !== 32'd0 || bus.pkt_rob_tag[1] !== 4'd0) begin n_fail++; $display("FAIL reset_pkt_fields got %0h/%0h want 0/0", bus.pkt_npc[0], bus.pkt_rob_tag[1]); end
    n_tests++; if (bus.mem_req_addr !== 32'd0 || bus.mem_req_data !== 32'd0) begin n_fail++; $display("FAIL reset_mem_req got %0h/%0h want 0/0", bus.mem_req_addr, bus.mem_req_data); end
    @(negedge clock);
    reset = 1'b1;
    m_total = 0;
  endtask

  task automatic test_dual_alu();
    @(negedge clock);
    bus.head_tag = 4'd15;
    set_slot(0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd5, 32'h0, 32'h1111);
    set_slot(1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd6, 32'h0, 32'h2222);
    #1;
    n_tests++; if (bus.commit_count !== 2'd2) begin n_fail++; $display("FAIL dual_count got %0d want 2", bus.commit_count); end
    @(posedge clock); #1;
    m_total += 2;
    n_tests++; if (bus.pkt_valid !== 2'b11 || bus.pkt_reg_wr_en !== 2'b11) begin n_fail++; $display("FAIL dual_valid_en got %b/%b want 11/11", bus.pkt_valid, bus.pkt_reg_wr_en); end
    n_tests++; if (bus.pkt_rob_tag[0] !== 4'd15 || bus.pkt_rob_tag[1] !== 4'd0) begin n_fail++; $display("FAIL dual_tags got %0d/%0d want 15/0", bus.pkt_rob_tag[0], bus.pkt_rob_tag[1]); end
    n_tests++; if (bus.pkt_reg_wr_idx[0] !== 5'd5 || bus.pkt_reg_wr_idx[1] !== 5'd6) begin n_fail++; $display("FAIL dual_idx got %0d/%0d want 5/6", bus.pkt_reg_wr_idx[0], bus.pkt_reg_wr_idx[1]); end
    n_tests++; if (bus.pkt_data_out[1] !== 32'h2222) begin n_fail++; $display("FAIL dual_data got %0h want 2222", bus.pkt_data_out[1]); end
    n_tests++; if (bus.retired_total !== 32'd2) begin n_fail++; $display("FAIL dual_total got %0d want 2", bus.retired_total); end
    clear_slots();
  endtask

  task automatic test_partial();
    @(negedge clock);
    bus.head_tag = 4'd2;
    set_slot(0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 32'h0, 32'h1);
    set_slot(1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd2, 32'h0, 32'h2);
    #1;
    n_tests++; if (bus.commit_count !== 2'd0) begin n_fail++; $display("FAIL partial_slot0_not_ready got %0d want 0", bus.commit_count); end
    bus.head_ready = 2'b01;
    #1;
    n_tests++; if (bus.commit_count !== 2'd1) begin n_fail++; $display("FAIL partial_slot1_not_ready got %0d want 1", bus.commit_count); end
    @(posedge clock); #1;
    m_total += 1;
    n_tests++; if (bus.pkt_valid !== 2'b01 || bus.pkt_reg_wr_en !== 2'b01) begin n_fail++; $display("FAIL partial_pkt got %b/%b want 01/01", bus.pkt_valid, bus.pkt_reg_wr_en); end
    n_tests++; if (bus.retired_total !== 32'(m_total)) begin n_fail++; $display("FAIL partial_total got %0d want %0d", bus.retired_total, m_total); end
    clear_slots();
  endtask

  task automatic test_store();
    @(negedge clock);
    bus.head_tag = 4'd3;
    bus.mem_ack  = 1'b0;
    set_slot(0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd7, 32'h0, 32'h77);
    set_slot(1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd0, 32'h100, 32'hDEAD);
    #1;
    n_tests++; if (bus.commit_count !== 2'd1) begin n_fail++; $display("FAIL store_alu_first got %0d want 1", bus.commit_count); end
    @(posedge clock); #1;
    m_total += 1;
    @(negedge clock);
    bus.head_tag = 4'd4;
    set_slot(0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd0, 32'h100, 32'hDEAD);
    set_slot(1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd8, 32'h0, 32'h88);
    #1;
    n_tests++; if (bus.commit_count !== 2'd0) begin n_fail++; $display("FAIL store_detect_count got %0d want 0", bus.commit_count); end
    @(posedge clock); #1;
    n_tests++; if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 32'h100 || bus.mem_req_data !== 32'hDEAD) begin n_fail++; $display("FAIL store_req got v=%0b a=%0h d=%0h want v=1 a=100 d=dead", bus.mem_req_valid, bus.mem_req_addr, bus.mem_req_data); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      bus.mem_ack = 1'b0;
      #1;
      n_tests++; if (bus.commit_count !== 2'd0) begin n_fail++; $display("FAIL store_wait_count[%0d] got %0d want 0", k, bus.commit_count); end
      @(posedge clock); #1;
      n_tests++; if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 32'h100) begin n_fail++; $display("FAIL store_hold[%0d] got v=%0b a=%0h want v=1 a=100", k, bus.mem_req_valid, bus.mem_req_addr); end
    end
    @(negedge clock);
    bus.mem_ack = 1'b1;
    #1;
    n_tests++; if (bus.commit_count !== 2'd1) begin n_fail++; $display("FAIL store_ack_count got %0d want 1", bus.commit_count); end
    @(posedge clock); #1;
    m_total += 1;
    n_tests++; if (bus.pkt_valid !== 2'b01 || bus.pkt_wr_mem[0] !== 1'b0 || bus.pkt_mem_address[0] !== 32'h100) begin n_fail++; $display("FAIL store_pkt got v=%b wm=%0b a=%0h want v=01 wm=0 a=100", bus.pkt_valid, bus.pkt_wr_mem[0], bus.pkt_mem_address[0]); end
    n_tests++; if (bus.mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL store_req_drop got %0b want 0", bus.mem_req_valid); end
    n_tests++; if (bus.retired_total !== 32'(m_total)) begin n_fail++; $display("FAIL store_total got %0d want %0d", bus.retired_total, m_total); end
    bus.mem_ack = 1'b0;
    clear_slots();
  endtask

  task automatic test_zero_reg();
    @(negedge clock);
    set_slot(0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 32'h5);
    set_slot(1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd9, 32'h0, 32'h6);
    @(posedge clock); #1;
    m_total += 2;
    n_tests++; if (bus.pkt_valid !== 2'b11 || bus.pkt_reg_wr_en !== 2'b10) begin n_fail++; $display("FAIL zero_reg got v=%b en=%b want v=11 en=10", bus.pkt_valid, bus.pkt_reg_wr_en); end
    clear_slots();
  endtask

  task automatic test_random();
    int cnt;
    bit st, ht;
    logic [31:0]      e_npc  [W];
    logic [31:0]      e_val  [W];
    logic [4:0]       e_rd   [W];
    logic [3:0]       e_tag  [W];
    logic [W-1:0]     e_mask;
    for (int c = 0; c < 300; c++) begin
      @(negedge clock);
      bus.head_tag = 4'($urandom);
      bus.mem_ack  = 1'($urandom);
      for (int i = 0; i < W; i++)
        set_slot(i, ($urandom % 4) != 0, ($urandom % 4) != 0, 1'b0, ($urandom % 5) == 0,
                 5'($urandom), $urandom, $urandom);
      #1;
      cnt = model_count(st, ht);
      n_tests++; if (int'(bus.commit_count) != cnt) begin n_fail++; $display("FAIL rand_count[%0d] got %0d want %0d", c, bus.commit_count, cnt); end
      e_mask = '0;
      for (int i = 0; i < W; i++) begin
        e_mask[i] = (i < cnt);
        e_npc[i]  = bus.head_npc[i];
        e_val[i]  = bus.head_value[i];
        e_rd[i]   = bus.head_dest_reg[i];
        e_tag[i]  = 4'((int'(bus.head_tag) + i) % ROB_DEPTH);
      end
      m_total += cnt;
      if (m_sw && bus.mem_ack) m_sw = 1'b0;
      else if (st) begin
        m_sw = 1'b1; m_addr = bus.head_dest_addr[0]; m_data = bus.head_value[0]; m_size = bus.head_mem_size[0];
      end
      @(posedge clock); #1;
      n_tests++; if (bus.pkt_valid !== e_mask) begin n_fail++; $display("FAIL rand_valid[%0d] got %b want %b", c, bus.pkt_valid, e_mask); end
      for (int i = 0; i < W; i++) begin
        if (e_mask[i]) begin
          n_tests++;
          if (bus.pkt_npc[i] !== e_npc[i] || bus.pkt_data_out[i] !== e_val[i] || bus.pkt_reg_wr_idx[i] !== e_rd[i] ||
              bus.pkt_rob_tag[i] !== e_tag[i] || bus.pkt_reg_wr_en[i] !== (e_rd[i] != 5'd0)) begin
            n_fail++;
            $display("FAIL rand_pkt[%0d][%0d] got npc=%0h d=%0h rd=%0d tag=%0d en=%0b want npc=%0h d=%0h rd=%0d tag=%0d",
                     c, i, bus.pkt_npc[i], bus.pkt_data_out[i], bus.pkt_reg_wr_idx[i], bus.pkt_rob_tag[i],
                     bus.pkt_reg_wr_en[i], e_npc[i], e_val[i], e_rd[i], e_tag[i]);
          end
        end else begin
          n_tests++; if (bus.pkt_reg_wr_en[i] !== 1'b0) begin n_fail++; $display("FAIL rand_idle_en[%0d][%0d] got %0b want 0", c, i, bus.pkt_reg_wr_en[i]); end
        end
      end
      n_tests++; if (bus.mem_req_valid !== m_sw) begin n_fail++; $display("FAIL rand_req_valid[%0d] got %0b want %0b", c, bus.mem_req_valid, m_sw); end
      if (m_sw) begin
        n_tests++; if (bus.mem_req_addr !== m_addr || bus.mem_req_data !== m_data || bus.mem_req_size !== m_size) begin n_fail++; $display("FAIL rand_req[%0d] got %0h/%0h/%0d want %0h/%0h/%0d", c, bus.mem_req_addr, bus.mem_req_data, bus.mem_req_size, m_addr, m_data, m_size); end
      end
      n_tests++; if (bus.retired_total !== 32'(m_total)) begin n_fail++; $display("FAIL rand_total[%0d] got %0d want %0d", c, bus.retired_total, m_total); end
    end
    if (m_sw) begin
      @(negedge clock);
      clear_slots();
      bus.mem_ack = 1'b1;
      @(posedge clock); #1;
      m_total += 1;
      m_sw = 1'b0;
    end
    @(negedge clock);
    bus.mem_ack = 1'b0;
    clear_slots();
  endtask

  task automatic test_reset_in_store();
    @(negedge clock);
    set_slot(0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd0, 32'h200, 32'hBEEF);
    @(posedge clock); #1;
    n_tests++; if (bus.mem_req_valid !== 1'b1) begin n_fail++; $display("FAIL rst_store_req got %0b want 1", bus.mem_req_valid); end
    #2;
    reset = 1'b0;
    #1;
    n_tests++; if (bus.mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rst_store_async got %0b want 0", bus.mem_req_valid); end
    n_tests++; if (bus.retired_total !== 32'd0) begin n_fail++; $display("FAIL rst_store_total got %0d want 0", bus.retired_total); end
    m_total = 0;
    m_sw    = 1'b0;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    clear_slots();
    set_slot(0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd3, 32'h0, 32'h33);
    #1;
    n_tests++; if (bus.commit_count !== 2'd1) begin n_fail++; $display("FAIL rst_fresh_count got %0d want 1", bus.commit_count); end
    @(posedge clock); #1;
    m_total = 1;
    n_tests++; if (bus.pkt_valid !== 2'b01 || bus.retired_total !== 32'd1) begin n_fail++; $display("FAIL rst_fresh_pkt got v=%b t=%0d want v=01 t=1", bus.pkt_valid, bus.retired_total); end
    clear_slots();
  endtask

  task automatic test_halt();
    @(negedge clock);
    set_slot(0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0, 32'h0);
    set_slot(1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd4, 32'h0, 32'h44);
    #1;
    n_tests++; if (bus.commit_count !== 2'd1) begin n_fail++; $display("FAIL halt_count got %0d want 1", bus.commit_count); end
    @(posedge clock); #1;
    m_total += 1;
    n_tests++; if (bus.halted !== 1'b1 || bus.pkt_valid !== 2'b01) begin n_fail++; $display("FAIL halt_rise got h=%0b v=%b want h=1 v=01", bus.halted, bus.pkt_valid); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      set_slot(0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd1, 32'h0, 32'h1);
      set_slot(1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd2, 32'h0, 32'h2);
      #1;
      n_tests++; if (bus.commit_count !== 2'd0) begin n_fail++; $display("FAIL halt_stuck_count[%0d] got %0d want 0", k, bus.commit_count); end
      @(posedge clock); #1;
      n_tests++; if (bus.halted !== 1'b1 || bus.retired_total !== 32'(m_total)) begin n_fail++; $display("FAIL halt_stuck[%0d] got h=%0b t=%0d want h=1 t=%0d", k, bus.halted, bus.retired_total, m_total); end
    end
    @(negedge clock);
    reset = 1'b0;
    #1;
    n_tests++; if (bus.halted !== 1'b0) begin n_fail++; $display("FAIL halt_reset_exit got %0b want 0", bus.halted); end
    @(negedge clock);
    reset = 1'b1;
    clear_slots();
  endtask

  initial begin
    test_reset();
    test_dual_alu();
    test_partial();
    test_store();
    test_zero_reg();
    test_random();
    test_reset_in_store();
    test_halt();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
